rram_pulse_seq: RTL and testbench

RRAM_PULSE_SEQ -- requirements
Module: rram_pulse_seq

---
 rtl/rram_pulse_seq_pkg.sv | 29 ++
 rtl/rram_phase_cnt.sv | 27 ++
 rtl/rram_pulse_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_rram_pulse_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rram_pulse_seq_pkg.sv
// Shared types for the RRAM pulse sequencer: FSM states, operation modes, status codes.
// No logic here; timing and flow control live in the modules that import it.
// Consumers: rram_pulse_seq and its testbench.
package rram_pulse_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_CP_BL,
        S_CP_GAP,
        S_CP_WL,
        S_RDWAIT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_WRITE  = 2'd0,
        MODE_READ   = 2'd1,
        MODE_CPULSE = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    localparam logic [1:0] STAT_OK    = 2'd0;
    localparam logic [1:0] STAT_ABORT = 2'd1;
    localparam logic [1:0] STAT_TMO   = 2'd2;

endpackage

// File: rtl/rram_phase_cnt.sv
// Loadable down-counter with zero flag; times every phase of the pulse sequencer.
// Latency: a load of N reads zero after N further clocks, so a phase lasts N+1 cycles.
// Backpressure: none; load wins over counting, and the count parks at zero.
module rram_phase_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rram_pulse_seq.sv
// RRAM write/read/charge-pulse sequencer driving the array's analog controls.
// Latency: setup+pulse+hold phases (each programmed length + 1 cycles), then a 1-cycle done.
// Backpressure: req is only accepted in IDLE; read waits on sa_rdy up to 2^TMO_W cycles.
module rram_pulse_seq
    import rram_pulse_seq_pkg::*;
#(
    parameter int WORD_W = 48,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8,
    parameter int BSL_W  = 5,
    parameter int WL_W   = 8,
    parameter int TMO_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [1:0]        mode,
    input  logic              set_rst_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [WORD_W-1:0] mask_in,
    input  logic [BSL_W-1:0]  bsl_cfg_in,
    input  logic [WL_W-1:0]   wl_cfg_in,
    input  logic [CNT_W-1:0]  setup_cyc,
    input  logic [CNT_W-1:0]  pw_cyc,
    input  logic [CNT_W-1:0]  hold_cyc,
    input  logic              all_dacs_on,
    input  logic              abort,
    input  logic              sa_rdy,
    input  logic [WORD_W-1:0] sa_do,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [WORD_W-1:0] rd_data,
    output logic              bl_en,
    output logic              sl_en,
    output logic              wl_en,
    output logic              we,
    output logic              aclk,
    output logic              sa_en,
    output logic              bsl_dac_en,
    output logic              wl_dac_en,
    output logic              bleed_en,
    output logic              read_dac_en,
    output logic [ADDR_W-1:0] rram_addr,
    output logic [WORD_W-1:0] di,
    output logic              set_rst,
    output logic [BSL_W-1:0]  bsl_dac_config,
    output logic [WL_W-1:0]   wl_dac_config
);

    state_e            state, state_n;
    mode_e             mode_q;
    logic [CNT_W-1:0]  setup_q, pw_q, hold_q;
    logic              accept, active;
    logic              ph_ld, ph_zero, tmo_ld, tmo_zero;
    logic [CNT_W-1:0]  ph_val;
    logic              abort_hit, tmo_hit, rd_cap;

    assign accept = (state == S_IDLE) && req && (mode != MODE_RSVD);
    assign active = (state != S_IDLE) && (state != S_DONE);

    rram_phase_cnt #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ph_ld),
        .load_val (ph_val),
        .zero     (ph_zero)
    );

    // Second instance bounds the sense-amp wait: loaded all-ones gives 2^TMO_W cycles.
    rram_phase_cnt #(.W(TMO_W)) u_tmo_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmo_ld),
        .load_val ({TMO_W{1'b1}}),
        .zero     (tmo_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q         <= MODE_WRITE;
            set_rst        <= 1'b0;
            rram_addr      <= '0;
            di             <= '0;
            bsl_dac_config <= '0;
            wl_dac_config  <= '0;
            setup_q        <= '0;
            pw_q           <= '0;
            hold_q         <= '0;
        end else if (accept) begin
            mode_q         <= mode_e'(mode);
            set_rst        <= set_rst_in;
            rram_addr      <= addr_in;
            di             <= (mode == MODE_READ) ? '0 : ~(mask_in ^ {WORD_W{set_rst_in}});
            bsl_dac_config <= bsl_cfg_in;
            wl_dac_config  <= wl_cfg_in;
            setup_q        <= setup_cyc;
            pw_q           <= pw_cyc;
            hold_q         <= hold_cyc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status  <= STAT_OK;
            rd_data <= '0;
        end else begin
            if (accept)
                status <= STAT_OK;
            else if (abort_hit)
                status <= STAT_ABORT;
            else if (tmo_hit)
                status <= STAT_TMO;
            if (rd_cap)
                rd_data <= sa_do;
        end
    end

    always_comb begin
        state_n   = state;
        ph_ld     = 1'b0;
        ph_val    = '0;
        tmo_ld    = 1'b0;
        abort_hit = 1'b0;
        tmo_hit   = 1'b0;
        rd_cap    = 1'b0;
        case (state)
            S_IDLE: if (accept) begin
                ph_ld = 1'b1;
                if (mode == MODE_CPULSE) begin
                    state_n = S_CP_BL;
                    ph_val  = pw_cyc;
                end else begin
                    state_n = S_SETUP;
                    ph_val  = setup_cyc;
                end
            end
            S_SETUP: if (ph_zero) begin
                if (mode_q == MODE_WRITE) begin
                    state_n = S_PULSE;
                    ph_ld   = 1'b1;
                    ph_val  = pw_q;
                end else begin
                    state_n = S_RDWAIT;
                    tmo_ld  = 1'b1;
                end
            end
            S_PULSE: if (ph_zero) begin
                state_n = S_HOLD;
                ph_ld   = 1'b1;
                ph_val  = hold_q;
            end
            S_HOLD:  if (ph_zero) state_n = S_DONE;
            S_CP_BL: if (ph_zero) state_n = S_CP_GAP;
            S_CP_GAP: begin
                state_n = S_CP_WL;
                ph_ld   = 1'b1;
                ph_val  = pw_q;
            end
            S_CP_WL: if (ph_zero) state_n = S_DONE;
            S_RDWAIT: begin
                if (sa_rdy) begin
                    state_n = S_HOLD;
                    ph_ld   = 1'b1;
                    ph_val  = hold_q;
                    rd_cap  = 1'b1;
                end else if (tmo_zero) begin
                    state_n = S_DONE;
                    tmo_hit = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // Abort overrides any transition chosen above, including a read capture.
        if (abort && active) begin
            state_n   = S_DONE;
            abort_hit = 1'b1;
            rd_cap    = 1'b0;
            tmo_hit   = 1'b0;
            ph_ld     = 1'b0;
            tmo_ld    = 1'b0;
        end
    end

    always_comb begin
        bl_en = 1'b0;
        sl_en = 1'b0;
        wl_en = 1'b0;
        we    = 1'b0;
        aclk  = 1'b0;
        sa_en = 1'b0;
        case (state)
            S_SETUP, S_HOLD: begin
                bl_en = 1'b1; sl_en = 1'b1; wl_en = 1'b1;
            end
            S_PULSE: begin
                bl_en = 1'b1; sl_en = 1'b1; wl_en = 1'b1; we = 1'b1; aclk = 1'b1;
            end
            S_RDWAIT: begin
                bl_en = 1'b1; sl_en = 1'b1; wl_en = 1'b1; sa_en = 1'b1;
            end
            S_CP_BL:  begin bl_en = 1'b1; sl_en = 1'b1; we = 1'b1; end
            S_CP_GAP: begin sl_en = 1'b1; we = 1'b1; end
            S_CP_WL:  begin sl_en = 1'b1; wl_en = 1'b1; we = 1'b1; end
            default: ;
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign bsl_dac_en  = all_dacs_on | (active && mode_q != MODE_READ);
    assign wl_dac_en   = all_dacs_on | (active && mode_q != MODE_READ);
    assign bleed_en    = all_dacs_on | (active && mode_q == MODE_READ);
    assign read_dac_en = all_dacs_on | (active && mode_q == MODE_READ);

endmodule

// File: tb/tb_rram_pulse_seq.sv
// Directed bench for rram_pulse_seq: per-cycle profile of each operation, checked against hand-computed timing.
module tb_rram_pulse_seq;

    localparam int WORD_W = 48;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 8;
    localparam int BSL_W  = 5;
    localparam int WL_W   = 8;
    localparam int TMO_W  = 4;

    logic              clk, rst_n, req, set_rst_in, all_dacs_on, abort, sa_rdy;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] addr_in;
    logic [WORD_W-1:0] mask_in, sa_do;
    logic [BSL_W-1:0]  bsl_cfg_in;
    logic [WL_W-1:0]   wl_cfg_in;
    logic [CNT_W-1:0]  setup_cyc, pw_cyc, hold_cyc;
    logic              busy, done, bl_en, sl_en, wl_en, we, aclk, sa_en;
    logic              bsl_dac_en, wl_dac_en, bleed_en, read_dac_en, set_rst;
    logic [1:0]        status;
    logic [WORD_W-1:0] rd_data, di;
    logic [ADDR_W-1:0] rram_addr;
    logic [BSL_W-1:0]  bsl_dac_config;
    logic [WL_W-1:0]   wl_dac_config;

    rram_pulse_seq #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
        .BSL_W(BSL_W), .WL_W(WL_W), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .set_rst_in(set_rst_in),
        .addr_in(addr_in), .mask_in(mask_in), .bsl_cfg_in(bsl_cfg_in), .wl_cfg_in(wl_cfg_in),
        .setup_cyc(setup_cyc), .pw_cyc(pw_cyc), .hold_cyc(hold_cyc),
        .all_dacs_on(all_dacs_on), .abort(abort), .sa_rdy(sa_rdy), .sa_do(sa_do),
        .busy(busy), .done(done), .status(status), .rd_data(rd_data),
        .bl_en(bl_en), .sl_en(sl_en), .wl_en(wl_en), .we(we), .aclk(aclk), .sa_en(sa_en),
        .bsl_dac_en(bsl_dac_en), .wl_dac_en(wl_dac_en), .bleed_en(bleed_en),
        .read_dac_en(read_dac_en), .rram_addr(rram_addr), .di(di), .set_rst(set_rst),
        .bsl_dac_config(bsl_dac_config), .wl_dac_config(wl_dac_config)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-operation profile, indexed from the first cycle after req is taken.
    int m_we_cnt, m_we_first, m_we_last, m_aclk_cnt, m_aclk_neq;
    int m_bl_cnt, m_bl_first, m_sl_cnt, m_wl_cnt, m_wl_first;
    int m_sa_cnt, m_bsl_cnt, m_bleed_cnt, m_done_idx;

    task automatic run_op(input logic [1:0] md, input logic sr, input logic [ADDR_W-1:0] ad,
                          input logic [WORD_W-1:0] mk, input logic [CNT_W-1:0] su,
                          input logic [CNT_W-1:0] pw, input logic [CNT_W-1:0] hd,
                          input int rdy_after, input int abort_after, input int busy_req_at);
        m_we_cnt = 0; m_we_first = -1; m_we_last = -1; m_aclk_cnt = 0; m_aclk_neq = 0;
        m_bl_cnt = 0; m_bl_first = -1; m_sl_cnt = 0; m_wl_cnt = 0; m_wl_first = -1;
        m_sa_cnt = 0; m_bsl_cnt = 0; m_bleed_cnt = 0; m_done_idx = -1;
        @(negedge clk);
        mode = md; set_rst_in = sr; addr_in = ad; mask_in = mk;
        setup_cyc = su; pw_cyc = pw; hold_cyc = hd; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (we) begin
                if (m_we_first < 0) m_we_first = i;
                m_we_last = i;
                m_we_cnt++;
            end
            if (aclk) m_aclk_cnt++;
            if (aclk !== we) m_aclk_neq++;
            if (bl_en) begin
                if (m_bl_first < 0) m_bl_first = i;
                m_bl_cnt++;
            end
            if (sl_en) m_sl_cnt++;
            if (wl_en) begin
                if (m_wl_first < 0) m_wl_first = i;
                m_wl_cnt++;
            end
            if (sa_en) m_sa_cnt++;
            if (bsl_dac_en) m_bsl_cnt++;
            if (bleed_en) m_bleed_cnt++;
            if (done) begin
                m_done_idx = i;
                break;
            end
            sa_rdy = (rdy_after > 0) && sa_en && (m_sa_cnt == rdy_after);
            abort  = (abort_after > 0) && we && (m_we_cnt == abort_after);
            if (i == busy_req_at) begin
                req = 1'b1; mode = 2'd0; addr_in = 16'h9999;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
        end
        sa_rdy = 1'b0; abort = 1'b0; req = 1'b0;
        chk("done_seen", 64'(m_done_idx >= 0), 64'd1);
    endtask

    initial begin
        int  busy_hits;
        logic seen;
        rst_n = 1'b0; req = 1'b0; mode = 2'd0; set_rst_in = 1'b0; addr_in = '0;
        mask_in = '0; bsl_cfg_in = '0; wl_cfg_in = '0; setup_cyc = '0; pw_cyc = '0;
        hold_cyc = '0; all_dacs_on = 1'b0; abort = 1'b0; sa_rdy = 1'b0; sa_do = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ctl", 64'({done, we, aclk, bl_en, sl_en, wl_en, sa_en}), 64'd0);
        chk("rst_dacs", 64'({bsl_dac_en, wl_dac_en, bleed_en, read_dac_en}), 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write: setup 2, pw 3, hold 1, SET.
        bsl_cfg_in = 5'h15; wl_cfg_in = 8'hC3;
        run_op(2'd0, 1'b1, 16'h1234, 48'h0000_FFFF_0F0F, 8'd2, 8'd3, 8'd1, 0, 0, -1);
        chk("wr_bl_first", 64'(m_bl_first), 64'd0);
        chk("wr_we_first", 64'(m_we_first), 64'd3);
        chk("wr_we_cnt", 64'(m_we_cnt), 64'd4);
        chk("wr_aclk_cnt", 64'(m_aclk_cnt), 64'd4);
        chk("wr_aclk_eq_we", 64'(m_aclk_neq), 64'd0);
        chk("wr_done_idx", 64'(m_done_idx), 64'(m_we_last + 3));
        chk("wr_done_abs", 64'(m_done_idx), 64'd9);
        chk("wr_bl_cnt", 64'(m_bl_cnt), 64'd9);
        chk("wr_bsl_dac", 64'(m_bsl_cnt), 64'd9);
        chk("wr_bleed", 64'(m_bleed_cnt), 64'd0);
        chk("wr_status", 64'(status), 64'd0);
        chk("wr_di", 64'(di), 64'h0000_FFFF_0F0F);
        chk("wr_addr", 64'(rram_addr), 64'h1234);
        chk("wr_set_rst", 64'(set_rst), 64'd1);
        chk("wr_cfg", 64'({bsl_dac_config, wl_dac_config}), 64'h15C3);
        @(negedge clk);
        chk("wr_after_done", 64'({busy, done}), 64'd0);

        // Read: setup 1, hold 0, sa_rdy in the 5th RDWAIT cycle.
        sa_do = 48'hA5A5;
        run_op(2'd1, 1'b1, 16'h0042, 48'hFFFF, 8'd1, 8'd0, 8'd0, 5, 0, -1);
        chk("rd_sa_cnt", 64'(m_sa_cnt), 64'd5);
        chk("rd_done_idx", 64'(m_done_idx), 64'd8);
        chk("rd_data", 64'(rd_data), 64'hA5A5);
        chk("rd_status", 64'(status), 64'd0);
        chk("rd_di", 64'(di), 64'd0);
        chk("rd_we_cnt", 64'(m_we_cnt), 64'd0);
        chk("rd_bleed", 64'(m_bleed_cnt), 64'd8);
        chk("rd_bsl_dac", 64'(m_bsl_cnt), 64'd0);

        // Charge pulse: pw 0, mask 0x0F, RESET polarity.
        run_op(2'd2, 1'b0, 16'h0007, 48'h0F, 8'd0, 8'd0, 8'd0, 0, 0, -1);
        chk("cp_di", 64'(di), 64'hFFFF_FFFF_FFF0);
        chk("cp_bl_cnt", 64'(m_bl_cnt), 64'd1);
        chk("cp_wl_cnt", 64'(m_wl_cnt), 64'd1);
        chk("cp_wl_first", 64'(m_wl_first), 64'd2);
        chk("cp_aclk", 64'(m_aclk_cnt), 64'd0);
        chk("cp_we_cnt", 64'(m_we_cnt), 64'd3);
        chk("cp_sl_cnt", 64'(m_sl_cnt), 64'd3);
        chk("cp_done_idx", 64'(m_done_idx), 64'd3);

        // Read timeout: sa_rdy never comes, 2^4 cycles of RDWAIT.
        sa_do = 48'h1111;
        run_op(2'd1, 1'b1, 16'h0050, 48'h0, 8'd0, 8'd0, 8'd0, 0, 0, -1);
        chk("tmo_sa_cnt", 64'(m_sa_cnt), 64'd16);
        chk("tmo_done_idx", 64'(m_done_idx), 64'd17);
        chk("tmo_status", 64'(status), 64'd2);
        chk("tmo_rd_data", 64'(rd_data), 64'hA5A5);

        // Abort in the 3rd pulse cycle, plus a req injected while busy.
        run_op(2'd0, 1'b1, 16'h00AB, 48'h3, 8'd0, 8'd10, 8'd0, 0, 3, 1);
        chk("ab_we_cnt", 64'(m_we_cnt), 64'd3);
        chk("ab_done_idx", 64'(m_done_idx), 64'(m_we_last + 1));
        chk("ab_status", 64'(status), 64'd1);
        busy_hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy) busy_hits++;
        end
        chk("ab_busy_req_ignored", 64'(busy_hits), 64'd0);
        chk("ab_addr", 64'(rram_addr), 64'h00AB);

        // all_dacs_on through reset and IDLE, then reset mid-write.
        all_dacs_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("dacs_in_rst", 64'({bsl_dac_en, wl_dac_en, bleed_en, read_dac_en}), 64'hF);
        chk("rst2_status", 64'(status), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("dacs_idle", 64'({bsl_dac_en, wl_dac_en, bleed_en, read_dac_en}), 64'hF);
        chk("rst2_rd_data", 64'(rd_data), 64'd0);
        mode = 2'd0; setup_cyc = 8'd1; pw_cyc = 8'd20; hold_cyc = 8'd0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = we;
        end
        chk("mid_we_seen", 64'(seen), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 64'({we, aclk, bl_en, sl_en, wl_en, busy}), 64'd0);
        chk("mid_rst_dacs", 64'({bsl_dac_en, wl_dac_en, bleed_en, read_dac_en}), 64'hF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
